// File: rtl/ssp_host_pkg.sv
// rtl/ssp_host_pkg.sv - shared constants and state type for the SSP host frame sequencer
package ssp_host_pkg;

    localparam logic [2:0] UCR = 3'b000;
    localparam logic [2:0] USR = 3'b001;
    localparam logic [2:0] TDR = 3'b010;
    localparam logic [2:0] RDR = 3'b011;
    localparam logic [2:0] SPR = 3'b100;

    localparam int         FRAME_BITS = 16;
    localparam logic [3:0] EN_BIT     = 4'd3;
    localparam logic [3:0] EOC_BIT    = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_CAPTURE,
        ST_RESP,
        ST_GAP
    } seq_state_t;

endpackage

// File: rtl/ssp_sck_gen.sv
// rtl/ssp_sck_gen.sv - SCK divider with predictive rise/fall strobes (asserted the cycle before sck changes)
// With run low the divider still counts and rise marks each half-period boundary while sck holds low.
module ssp_sck_gen #(
    parameter int SCK_DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int            DW       = (SCK_DIV < 2) ? 1 : $clog2(SCK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = en && (div_cnt == DIV_LAST);
    assign rise = tick && !sck;
    assign fall = tick && sck;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick && run) begin
                sck <= ~sck;
            end
        end
    end

endmodule

// File: rtl/ssp_host_seq.sv
// rtl/ssp_host_seq.sv - host-side SSP frame sequencer: one command in, one 16-bit frame out, one response back
module ssp_host_seq
    import ssp_host_pkg::*;
#(
    parameter int SCK_DIV = 3,
    parameter int GAP_CYC = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_ra,
    input  logic        cmd_wnr,
    input  logic [11:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_ra,
    output logic        rsp_wnr,
    output logic [11:0] rsp_rdata,
    output logic        SSP_SSEL,
    output logic        SSP_SCK,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic [11:0] SSP_DI,
    output logic        SSP_En,
    output logic        SSP_EOC,
    input  logic [11:0] SSP_DO
);

    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);
    localparam int            GW       = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    seq_state_t    state, state_nx;
    logic [3:0]    bit_cnt, bit_cnt_nx;
    logic [GW-1:0] gap_cnt;
    logic          accept, rsp_fire, gap_done;
    logic          sck_en, sck_run, sck_rise, sck_fall;
    logic          ssel_d, en_d, eoc_d, cmd_ready_d, rsp_valid_d;

    assign accept   = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign gap_done = (GAP_CYC == 0) || (gap_cnt == GAP_LAST);
    assign sck_en   = (state == ST_SETUP) || (state == ST_SHIFT);
    assign sck_run  = (state == ST_SHIFT);

    // SETUP reuses the divider with SCK frozen low; SHIFT then adds its own low half before the first rise.
    ssp_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clk  (Clk),
        .rst  (Rst),
        .clr  (!sck_en),
        .en   (sck_en),
        .run  (sck_run),
        .sck  (SSP_SCK),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (accept) state_nx = ST_SETUP;
            ST_SETUP:   if (sck_rise) state_nx = ST_SHIFT;
            ST_SHIFT:   if (sck_fall && (bit_cnt == LAST_BIT)) state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_RESP;
            ST_RESP:    if (rsp_fire) state_nx = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:     if (gap_done) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        bit_cnt_nx = '0;
        if (state == ST_SHIFT) begin
            bit_cnt_nx = bit_cnt + {3'b000, sck_fall};
        end
        ssel_d      = state_nx inside {ST_SETUP, ST_SHIFT, ST_CAPTURE};
        en_d        = (state_nx == ST_SHIFT) && (bit_cnt_nx == EN_BIT);
        eoc_d       = (state_nx == ST_SHIFT) && (bit_cnt_nx == EOC_BIT);
        cmd_ready_d = (state_nx == ST_IDLE);
        rsp_valid_d = (state_nx == ST_RESP);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_ra    <= '0;
            rsp_wnr   <= 1'b0;
            rsp_rdata <= '0;
            SSP_SSEL  <= 1'b0;
            SSP_RA    <= '0;
            SSP_WnR   <= 1'b0;
            SSP_DI    <= '0;
            SSP_En    <= 1'b0;
            SSP_EOC   <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nx;
            gap_cnt   <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            SSP_SSEL  <= ssel_d;
            SSP_En    <= en_d;
            SSP_EOC   <= eoc_d;
            if (accept) begin
                SSP_RA  <= cmd_ra;
                SSP_WnR <= cmd_wnr;
                SSP_DI  <= cmd_wdata;
            end
            if (state == ST_CAPTURE) begin
                rsp_rdata <= SSP_DO;
                rsp_ra    <= SSP_RA;
                rsp_wnr   <= SSP_WnR;
            end
        end
    end

endmodule

// File: doc/ssp_host_seq.md
Name: ssp_host_seq

Overview:
Host-side SSP frame sequencer that sits directly upstream of ssp_uart and drives its SSP slave port.
- Accepts single register commands (RA, WnR, 12-bit data) on a valid/ready interface.
- Generates one 16-bit SSP frame per command (SSEL, SCK, RA, WnR, DI, En, EOC).
- Captures SSP_DO at end of frame and returns it on a valid/ready response channel.
- One transaction outstanding at a time; replaces hand-driven SSP stimulus in bench and system use.

Parameters:
SCK_DIV, 3, Clk cycles per SCK half-period (>=1); SCK period = 2*SCK_DIV Clk cycles.
GAP_CYC, 4, idle Clk cycles with SSEL low between response handshake and next cmd_ready.

Ports:
Clk  in  1  system clock; all logic on rising edge.
Rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_ra  in  3  target register address (UCR/USR/TDR/RDR/SPR).
cmd_wnr  in  1  1 = write, 0 = read.
cmd_wdata  in  12  write data (don't-care for reads; driven on DI anyway).
rsp_valid  out  1  response present; held until rsp_ready.
rsp_ready  in  1  response consumed.
rsp_ra  out  3  RA of completed command.
rsp_wnr  out  1  WnR of completed command.
rsp_rdata  out  12  SSP_DO sampled at frame end.
SSP_SSEL  out  1  frame select, active high.
SSP_SCK  out  1  serial clock, idles low.
SSP_RA  out  3  register address for the frame.
SSP_WnR  out  1  write/not-read for the frame.
SSP_DI  out  12  write data to ssp_uart.
SSP_En  out  1  register-access enable.
SSP_EOC  out  1  end-of-cycle strobe.
SSP_DO  in  12  read data from ssp_uart.

Behaviour:
- All outputs are registered. Reset value of every output is 0, except cmd_ready = 0 during reset and 1 on the first cycle after Rst falls.
- States: IDLE, SETUP, SHIFT, CAPTURE, RESP, GAP.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On accept (edge E0): latch RA/WnR/wdata; go SETUP.
  - After E0: SSEL = 1, SCK = 0, SSP_RA/SSP_WnR/SSP_DI = latched values.
  - SSP_RA/SSP_WnR/SSP_DI stay stable until SSEL falls.
- SETUP: SCK held low for SCK_DIV cycles, then SHIFT.
- SHIFT:
  - SCK toggles every SCK_DIV cycles, giving exactly 16 rising edges.
  - bit_cnt (4-bit) starts at 0 and increments on each SCK falling edge.
  - SSP_En = 1 while bit_cnt == 3 (one full SCK period; 2*SCK_DIV Clk cycles).
  - SSP_EOC = 1 while bit_cnt == 15.
  - After the 16th falling edge (E at 33*SCK_DIV), go CAPTURE. bit_cnt wrap 15 -> 0 is ignored.
- CAPTURE: one cycle.
  - Sample SSP_DO into rsp_rdata; drop SSEL.
  - rsp_valid asserts after edge 33*SCK_DIV+1; SSEL high time = 33*SCK_DIV+1 cycles.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On handshake: rsp_valid = 0 next cycle; go GAP.
- GAP: GAP_CYC cycles, then IDLE. GAP_CYC = 0 means straight to IDLE.
- Writes also produce a response; rsp_rdata = sampled SSP_DO.
- cmd_valid outside IDLE is ignored; commands are never dropped silently (cmd_ready low).
- Rst mid-operation: next cycle all outputs 0, no response is generated, and the in-flight command is discarded.

Decomposition:
- Package ssp_host_pkg:
  - register address constants UCR=3'b000, USR=3'b001, TDR=3'b010, RDR=3'b011, SPR=3'b100;
  - FRAME_BITS=16, EN_BIT=3, EOC_BIT=15;
  - state enum type.
- Sub-module ssp_sck_gen: divider producing SSP_SCK plus single-cycle rise/fall strobes, with enable and synchronous clear.

Test Plan:
- Hold Rst high 10 cycles -> all outputs 0 during reset; cmd_ready = 1 on the first cycle after release; SCK stays low.
- Write UCR, wdata 12'h5A3, SCK_DIV=3 -> SSEL high 100 cycles; 16 SCK pulses of period 6; RA=0, WnR=1, DI=12'h5A3 stable; En high 6 cycles (bit 3 only); EOC high during bit 15; rsp_valid at cycle 100 after accept.
- Read USR with SSP_DO stubbed 12'hABC -> rsp_rdata=12'hABC, rsp_ra=1, rsp_wnr=0.
- Hold rsp_ready=0 for 50 cycles with second cmd_valid high -> rsp_* stable, cmd_ready 0, SSEL low; after handshake, 4 GAP cycles, then second command accepted.
- Assert Rst for 1 cycle at bit_cnt 8 -> SSEL/SCK/En/EOC 0 next cycle, no rsp_valid; next command completes normally.
- Instance with SCK_DIV=1 -> SCK period 2 cycles; rsp_valid 34 cycles after accept; En high 2 cycles.
